gray_step_tracker: RTL and testbench

//  Downstream consumer of the 2-bit Gray-code counter outputs (q1,q0). Samples the code each clock,

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_delta.sv | 21 ++
 rtl/gray_step_tracker.sv | 138 +++++++++++++
 tb/tb_gray_step_tracker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code step tracker.
//   state_e  : tracker FSM states (prime after reset, normal tracking, sticky fault)
//   delta_e  : classification of the change between two consecutive samples
//   gray2bin : 2-bit Gray to binary decode
package gray_pkg;

    typedef enum logic [1:0] {
        StPrime = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } state_e;

    // Encoded so that the value equals (bin_new - bin_old) mod 4.
    typedef enum logic [1:0] {
        DNone = 2'd0,
        DUp   = 2'd1,
        DErr  = 2'd2,
        DDn   = 2'd3
    } delta_e;

    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

endpackage

// File: rtl/gray_delta.sv
// Combinational classifier for a pair of 2-bit Gray samples.
//   cur_i   : newer Gray sample
//   prev_i  : older Gray sample
//   delta_o : DNone / DUp / DDn / DErr
module gray_delta
    import gray_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic [1:0] prev_i,
    output delta_e     delta_o
);

    logic [1:0] diff;

    always_comb begin
        // Modulo-4 difference of the decoded positions maps directly onto delta_e.
        diff    = gray2bin(cur_i) - gray2bin(prev_i);
        delta_o = delta_e'(diff);
    end

endmodule

// File: rtl/gray_step_tracker.sv
// Tracks a 2-bit Gray-code counter: samples (q1,q0) every clock, decodes to binary,
// classifies each transition and keeps a wrapping position and a saturating error count.
// An illegal (two-bit) jump drives a sticky fault that only clear or reset removes.
//   clk, reset  : clock, synchronous active-high reset
//   q1, q0      : Gray code from the counter
//   clear       : zero position/err_count and leave FAULT
//   bin         : registered binary decode of the latest sample
//   valid       : two real samples held, step pulses are meaningful
//   step_up/dn/err : one-cycle transition pulses
//   fault       : sticky illegal-jump flag
//   position    : wrapping up/down step count
//   err_count   : saturating illegal-jump count
module gray_step_tracker
    import gray_pkg::*;
#(
    parameter int unsigned POS_W = 8,
    parameter int unsigned ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q1,
    input  logic             q0,
    input  logic             clear,
    output logic [1:0]       bin,
    output logic             valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_err,
    output logic             fault,
    output logic [POS_W-1:0] position,
    output logic [ERR_W-1:0] err_count
);

    logic [1:0]       s0_q, s0_d, s1_q, s1_d;
    logic [1:0]       bin_q, bin_d;
    logic             prime_q, prime_d;
    state_e           state_q, state_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             step_err_q, step_err_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [ERR_W-1:0] err_q, err_d;
    delta_e           delta;

    gray_delta u_gray_delta (
        .cur_i   (s0_q),
        .prev_i  (s1_q),
        .delta_o (delta)
    );

    always_comb begin
        s0_d       = {q1, q0};
        s1_d       = s0_q;
        bin_d      = gray2bin({q1, q0});
        prime_d    = prime_q;
        state_d    = state_q;
        step_up_d  = 1'b0;
        step_dn_d  = 1'b0;
        step_err_d = 1'b0;
        pos_d      = pos_q;
        err_d      = err_q;

        // Pulses reflect the sample pair whenever the pair is meaningful.
        if (state_q != StPrime) begin
            step_up_d  = (delta == DUp);
            step_dn_d  = (delta == DDn);
            step_err_d = (delta == DErr);
            if (delta == DErr && err_q != '1) begin
                err_d = err_q + 1'b1;
            end
        end

        unique case (state_q)
            StPrime: begin
                // Second sampled edge after reset fills s1 with a real sample.
                prime_d = 1'b1;
                if (prime_q) begin
                    state_d = StTrack;
                end
            end
            StTrack: begin
                unique case (delta)
                    DUp:     pos_d = pos_q + 1'b1;
                    DDn:     pos_d = pos_q - 1'b1;
                    DErr:    state_d = StFault;
                    default: ;
                endcase
            end
            StFault: ;
            default: state_d = StPrime;
        endcase

        // Clear overrides this cycle's accounting; pulses above stay untouched.
        if (clear) begin
            pos_d = '0;
            err_d = '0;
            if (state_q != StPrime) begin
                state_d = StTrack;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q       <= 2'b00;
            s1_q       <= 2'b00;
            bin_q      <= 2'b00;
            prime_q    <= 1'b0;
            state_q    <= StPrime;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            step_err_q <= 1'b0;
            pos_q      <= '0;
            err_q      <= '0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            bin_q      <= bin_d;
            prime_q    <= prime_d;
            state_q    <= state_d;
            step_up_q  <= step_up_d;
            step_dn_q  <= step_dn_d;
            step_err_q <= step_err_d;
            pos_q      <= pos_d;
            err_q      <= err_d;
        end
    end

    assign bin       = bin_q;
    assign valid     = (state_q != StPrime);
    assign fault     = (state_q == StFault);
    assign step_up   = step_up_q;
    assign step_dn   = step_dn_q;
    assign step_err  = step_err_q;
    assign position  = pos_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
module tb_gray_step_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       q1 = 1'b0;
    logic       q0 = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] bin;
    logic       valid, step_up, step_dn, step_err, fault;
    logic [7:0] position;
    logic [3:0] err_count;

    gray_step_tracker #(
        .POS_W (8),
        .ERR_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .q1        (q1),
        .q0        (q0),
        .clear     (clear),
        .bin       (bin),
        .valid     (valid),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .step_err  (step_err),
        .fault     (fault),
        .position  (position),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Gray<->binary for 2 bits is the same lookup in both directions.
    int g_tab[4] = '{0, 1, 3, 2};

    // Reference model state.
    int n_edges = 0;          // edges since reset, capped
    int hist[$];              // sampled codes since reset
    int m_pos = 0;
    int m_err = 0;
    bit m_fault = 0;
    int e_up, e_dn, e_err, e_bin, e_valid;
    int cb = 0;               // bench's notion of the current binary position

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int code, input bit clr, input bit rst);
        int d;
        e_up = 0; e_dn = 0; e_err = 0;
        if (rst) begin
            n_edges = 0; hist.delete();
            m_pos = 0; m_err = 0; m_fault = 0;
            e_bin = 0; e_valid = 0;
            return;
        end
        if (n_edges < 3) n_edges++;
        if (n_edges >= 3) begin
            d = (g_tab[hist[hist.size()-1]] - g_tab[hist[hist.size()-2]] + 4) % 4;
            e_up  = (d == 1);
            e_dn  = (d == 3);
            e_err = (d == 2);
            if (d == 2 && m_err < 15) m_err++;
            if (!m_fault) begin
                if (d == 1) m_pos = (m_pos + 1) % 256;
                if (d == 3) m_pos = (m_pos + 255) % 256;
                if (d == 2) m_fault = 1;
            end
        end
        if (clr) begin
            m_pos = 0; m_err = 0; m_fault = 0;
        end
        hist.push_back(code);
        if (hist.size() > 4) void'(hist.pop_front());
        e_bin   = g_tab[code];
        e_valid = (n_edges >= 2);
    endtask

    task automatic cycle(input int code, input bit clr, input bit rst);
        q1    = code[1];
        q0    = code[0];
        clear = clr;
        reset = rst;
        @(posedge clk);
        model_edge(code, clr, rst);
        #1;
        check_eq("bin",       32'(bin),       32'(e_bin));
        check_eq("valid",     32'(valid),     32'(e_valid));
        check_eq("step_up",   32'(step_up),   32'(e_up));
        check_eq("step_dn",   32'(step_dn),   32'(e_dn));
        check_eq("step_err",  32'(step_err),  32'(e_err));
        check_eq("fault",     32'(fault),     32'(m_fault));
        check_eq("position",  32'(position),  32'(m_pos));
        check_eq("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic move(input int delta, input bit clr);
        cb = (cb + delta) % 4;
        cycle(g_tab[cb], clr, 1'b0);
    endtask

    initial begin
        int r;
        bit clr, rst;

        // 1: reset then hold 00
        cycle(0, 0, 1); cb = 0;
        repeat (5) cycle(0, 0, 0);
        check_eq("t1_valid", 32'(valid), 32'd1);
        check_eq("t1_pos", 32'(position), 32'd0);

        // 2: one forward lap
        repeat (4) move(1, 0);
        move(0, 0);
        check_eq("t2_pos", 32'(position), 32'd4);
        check_eq("t2_bin", 32'(bin), 32'd0);

        // 3: wrap up and down
        cycle(0, 0, 1); cb = 0;
        repeat (2) cycle(0, 0, 0);
        repeat (255) move(1, 0);
        move(0, 0);
        check_eq("t3_pos255", 32'(position), 32'd255);
        move(1, 0); move(0, 0);
        check_eq("t3_wrap0", 32'(position), 32'd0);
        move(3, 0);
        move(0, 0);
        check_eq("t3_dn_pulse", 32'(step_dn), 32'd1);
        check_eq("t3_pos_dn", 32'(position), 32'd255);

        // 4: illegal jump, frozen position, saturation
        move(2, 0); move(0, 0);
        check_eq("t4_err_pulse", 32'(step_err), 32'd1);
        check_eq("t4_fault", 32'(fault), 32'd1);
        check_eq("t4_err1", 32'(err_count), 32'd1);
        repeat (3) move(1, 0);
        move(0, 0);
        check_eq("t4_frozen", 32'(position), 32'd255);
        repeat (17) move(2, 0);
        move(0, 0);
        check_eq("t4_sat", 32'(err_count), 32'd15);

        // 5: clear on the edge that accounts an up step while in FAULT
        move(1, 0);
        move(0, 1);
        check_eq("t5_up_pulse", 32'(step_up), 32'd1);
        check_eq("t5_pos", 32'(position), 32'd0);
        check_eq("t5_err", 32'(err_count), 32'd0);
        check_eq("t5_fault", 32'(fault), 32'd0);
        move(1, 0); move(0, 0);
        check_eq("t5_next", 32'(position), 32'd1);

        // 6: reset with clear mid-sequence
        move(1, 0);
        cycle(g_tab[(cb + 1) % 4], 1, 1); cb = (cb + 1) % 4;
        check_eq("t6_valid0", 32'(valid), 32'd0);
        check_eq("t6_pos", 32'(position), 32'd0);
        move(1, 0);
        check_eq("t6_valid1", 32'(valid), 32'd0);
        move(1, 0);
        check_eq("t6_valid2", 32'(valid), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(0, 9));
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if (r < 4)       cb = (cb + 1) % 4;
            else if (r < 6)  cb = (cb + 3) % 4;
            else if (r == 8) cb = (cb + 2) % 4;
            else if (r == 9) cb = int'($urandom_range(0, 3));
            cycle(g_tab[cb], clr, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
